// File: rtl/horner_frame_parser.sv
// Frame parser for the Horner evaluation core: splits one AXI-Stream frame into header,
// weight writes, a latched 3x4 matrix and a tagged, back-pressured vector stream.
module horner_frame_parser #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int W_WIDTH    = 32,
    parameter int ORI_NUM    = 4,
    parameter int INT_NUM    = 6,
    parameter int LAY_NUM    = 2,
    parameter int WEIGHT_NUM = 3*ORI_NUM + INT_NUM - LAY_NUM + 3
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [LANES*DATA_WIDTH-1:0]   s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    input  logic                          s_tlast,
    output logic                          w_we,
    output logic [4:0]                    w_addr,
    output logic [W_WIDTH-1:0]            w_data,
    output logic [12*DATA_WIDTH-1:0]      mat,
    output logic                          mat_valid,
    output logic [15:0]                   cal_num,
    output logic [LANES*DATA_WIDTH-1:0]   v_tdata,
    output logic [1:0]                    v_class,
    output logic [15:0]                   v_idx,
    output logic                          v_tvalid,
    input  logic                          v_tready,
    output logic                          v_tlast,
    output logic                          frame_done,
    output logic                          err,
    output logic [2:0]                    o_dbg_state
);

    localparam int          BEAT_W   = LANES*DATA_WIDTH;
    localparam logic [4:0]  WGT_LAST = 5'(WEIGHT_NUM-1);
    localparam logic [15:0] ORI_LAST = 16'(ORI_NUM-1);
    localparam logic [15:0] INT_LAST = 16'(INT_NUM-1);
    localparam logic [15:0] LAY_LAST = 16'(LAY_NUM-1);

    // Handshake: a beat moves on either stream only in a cycle where valid && ready are
    // both high; valid never depends on ready, and the output holds while valid && !ready.
    typedef enum logic [2:0] {ST_HDR, ST_WGT, ST_MAT, ST_VEC, ST_DRN} state_t;

    state_t                r_state, w_next;
    logic [4:0]            r_wcnt;
    logic [1:0]            r_mrow;
    logic [1:0]            r_cls;
    logic [15:0]           r_cnt;
    logic [15:0]           r_cal;
    logic [12*DATA_WIDTH-1:0] r_mat;
    logic                  r_mat_valid;
    logic                  r_err;
    logic [BEAT_W-1:0]     r_v_data;
    logic [1:0]            r_v_class;
    logic [15:0]           r_v_idx;
    logic                  r_v_valid;
    logic                  r_v_last;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_last_vec;
    logic                  w_wr;

    // The final vector is the last layer vector when there are no input points.
    assign w_last_vec = ((r_cls == 2'd2) && (r_cnt == LAY_LAST) && (r_cal == 16'd0)) ||
                        ((r_cls == 2'd3) && (r_cnt == r_cal - 16'd1));
    assign w_accept   = s_tvalid && w_ready;

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b1;
        w_wr    = 1'b0;
        case (r_state)
            ST_HDR: if (w_accept) w_next = ST_WGT;
            ST_WGT: begin
                w_wr = s_tvalid;
                if (w_accept && r_wcnt == WGT_LAST) w_next = ST_MAT;
            end
            ST_MAT: if (w_accept && r_mrow == 2'd2) w_next = ST_VEC;
            ST_VEC: begin
                w_ready = !r_v_valid || v_tready;
                if (w_accept && w_last_vec) w_next = ST_DRN;
            end
            ST_DRN: begin
                w_ready = 1'b0;
                if (r_v_valid && v_tready) w_next = ST_HDR;
            end
            default: w_next = ST_HDR;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= ST_HDR;
        else        r_state <= w_next;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wcnt      <= '0;
            r_mrow      <= '0;
            r_cls       <= '0;
            r_cnt       <= '0;
            r_cal       <= '0;
            r_mat       <= '0;
            r_mat_valid <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_accept) begin
            if (r_state == ST_HDR) r_err <= s_tlast;
            else if (s_tlast && !(r_state == ST_VEC && w_last_vec)) r_err <= 1'b1;
            case (r_state)
                ST_HDR: begin
                    r_cal       <= s_tdata[15:0];
                    r_mat_valid <= 1'b0;
                    r_wcnt      <= '0;
                    r_mrow      <= '0;
                    r_cls       <= '0;
                    r_cnt       <= '0;
                end
                ST_WGT: r_wcnt <= (r_wcnt == WGT_LAST) ? 5'd0 : r_wcnt + 5'd1;
                ST_MAT: begin
                    case (r_mrow)
                        2'd0:    r_mat[0        +: BEAT_W] <= s_tdata;
                        2'd1:    r_mat[BEAT_W   +: BEAT_W] <= s_tdata;
                        default: r_mat[2*BEAT_W +: BEAT_W] <= s_tdata;
                    endcase
                    if (r_mrow == 2'd2) begin
                        r_mat_valid <= 1'b1;
                        r_mrow      <= 2'd0;
                    end else begin
                        r_mrow <= r_mrow + 2'd1;
                    end
                end
                ST_VEC: begin
                    // Class boundaries fall on fixed counts; the input class runs cal_num long.
                    case (r_cls)
                        2'd0:    if (r_cnt == ORI_LAST) begin r_cls <= 2'd1; r_cnt <= '0; end
                                 else r_cnt <= r_cnt + 16'd1;
                        2'd1:    if (r_cnt == INT_LAST) begin r_cls <= 2'd2; r_cnt <= '0; end
                                 else r_cnt <= r_cnt + 16'd1;
                        2'd2:    if (r_cnt == LAY_LAST) begin r_cls <= 2'd3; r_cnt <= '0; end
                                 else r_cnt <= r_cnt + 16'd1;
                        default: r_cnt <= r_cnt + 16'd1;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_v_data  <= '0;
            r_v_class <= '0;
            r_v_idx   <= '0;
            r_v_valid <= 1'b0;
            r_v_last  <= 1'b0;
        end else if (w_accept && r_state == ST_VEC) begin
            r_v_data  <= s_tdata;
            r_v_class <= r_cls;
            r_v_idx   <= r_cnt;
            r_v_valid <= 1'b1;
            r_v_last  <= w_last_vec;
        end else if (v_tready) begin
            r_v_valid <= 1'b0;
        end
    end

    assign s_tready    = w_ready;
    assign w_we        = w_wr;
    assign w_addr      = r_wcnt;
    assign w_data      = w_wr ? s_tdata[W_WIDTH-1:0] : '0;
    assign mat         = r_mat;
    assign mat_valid   = r_mat_valid;
    assign cal_num     = r_cal;
    assign v_tdata     = r_v_data;
    assign v_class     = r_v_class;
    assign v_idx       = r_v_idx;
    assign v_tvalid    = r_v_valid;
    assign v_tlast     = r_v_last;
    assign frame_done  = (r_state == ST_DRN) && r_v_valid && v_tready;
    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_horner_frame_parser.sv
// Directed bench for horner_frame_parser: a table of frame records driven through one
// frame task, plus a hand-written mid-frame reset sequence.
module tb_horner_frame_parser;

    logic          aclk;
    logic          areset;
    logic [63:0]   s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic          w_we;
    logic [4:0]    w_addr;
    logic [31:0]   w_data;
    logic [191:0]  mat;
    logic          mat_valid;
    logic [15:0]   cal_num;
    logic [63:0]   v_tdata;
    logic [1:0]    v_class;
    logic [15:0]   v_idx;
    logic          v_tvalid;
    logic          v_tready;
    logic          v_tlast;
    logic          frame_done;
    logic          err;
    logic [2:0]    o_dbg_state;

    horner_frame_parser dut (
        .aclk(aclk), .areset(areset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .mat(mat), .mat_valid(mat_valid), .cal_num(cal_num),
        .v_tdata(v_tdata), .v_class(v_class), .v_idx(v_idx), .v_tvalid(v_tvalid),
        .v_tready(v_tready), .v_tlast(v_tlast), .frame_done(frame_done), .err(err),
        .o_dbg_state(o_dbg_state)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        int   cal;
        int   bad_w;
        int   bp;
        int   gap;
        int   stop_after;
        int   exp_nvec;
        logic exp_err;
        int   exp_last_cls;
        int   exp_last_idx;
    } frame_t;

    int          n_vec;
    int          n_miss;
    int          bp_mode;
    int          xfer_cnt;
    int          fd_cnt;
    int          last_cls;
    int          last_idx;
    logic [31:0] wt[19];
    logic [82:0] exp_q[$];
    frame_t      tbl[9];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    function automatic frame_t mk(int cal, int bad_w, int bp, int gap, int stop_after,
                                  int exp_nvec, logic exp_err, int lc, int li);
        frame_t f;
        f.cal = cal; f.bad_w = bad_w; f.bp = bp; f.gap = gap; f.stop_after = stop_after;
        f.exp_nvec = exp_nvec; f.exp_err = exp_err; f.exp_last_cls = lc; f.exp_last_idx = li;
        return f;
    endfunction

    // Downstream ready: always, a 1,0,0,1 pattern, or random.
    initial begin
        int ph;
        ph = 0;
        v_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (bp_mode)
                0: v_tready = 1'b1;
                1: begin v_tready = ((ph % 4) == 0) || ((ph % 4) == 3); ph++; end
                default: v_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor / scoreboard.
    initial begin
        logic        held;
        logic [82:0] saved;
        logic [82:0] e;
        held = 1'b0;
        saved = '0;
        forever begin
            @(negedge aclk);
            if (held && !areset)
                chk("hold_stable", 192'({v_tvalid, v_tdata, v_class, v_idx, v_tlast}), 192'({1'b1, saved}));
            if (!v_tvalid) chk("s_tready_idle", 192'(s_tready), 192'(1'b1));
            if (v_tvalid && !v_tready) chk("s_tready_held", 192'(s_tready), 192'(1'b0));
            if (v_tvalid && v_tready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_vector: got %0h, expected none", v_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("vector", 192'({v_tdata, v_class, v_idx, v_tlast}), 192'(e));
                end
                chk("frame_done", 192'(frame_done), 192'(v_tlast));
                xfer_cnt++;
                if (v_tlast) begin last_cls = int'(v_class); last_idx = int'(v_idx); end
                if (frame_done) fd_cnt++;
            end else begin
                chk("frame_done_idle", 192'(frame_done), 192'(1'b0));
            end
            held  = v_tvalid && !v_tready;
            saved = {v_tdata, v_class, v_idx, v_tlast};
        end
    end

    task automatic send(input logic [63:0] d, input logic last, input logic is_w,
                        input int widx, input logic [31:0] wval, output int stall);
        logic done;
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = last;
        stall    = 0;
        done     = 1'b0;
        for (int waited = 0; waited < 300 && !done; waited++) begin
            @(negedge aclk);
            if (s_tready) begin
                done = 1'b1;
                if (is_w) begin
                    chk("w_we", 192'(w_we), 192'(1'b1));
                    chk("w_addr", 192'(w_addr), 192'(widx));
                    chk("w_data", 192'(w_data), 192'(wval));
                end else begin
                    chk("w_we_off", 192'(w_we), 192'(1'b0));
                end
            end else begin
                stall++;
            end
            @(posedge aclk);
            #1;
        end
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("FAIL send_timeout: got no s_tready, expected accept within 300 cycles");
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_s_tready", 192'(s_tready), 192'(1'b1));
        chk("rst_w", 192'({w_we, w_addr, w_data}), 192'(0));
        chk("rst_mat", 192'(mat), 192'(0));
        chk("rst_mat_valid", 192'(mat_valid), 192'(1'b0));
        chk("rst_cal_num", 192'(cal_num), 192'(0));
        chk("rst_vout", 192'({v_tvalid, v_tdata, v_class, v_idx, v_tlast}), 192'(0));
        chk("rst_frame_done", 192'(frame_done), 192'(1'b0));
        chk("rst_err", 192'(err), 192'(1'b0));
    endtask

    task automatic run_frame(input frame_t f);
        int          st;
        int          tot_stall;
        int          nvec;
        int          cls;
        int          idx;
        logic [63:0] rows[3];
        logic [63:0] d;
        bp_mode = f.bp;
        for (int g = 0; g < f.gap; g++) begin @(posedge aclk); #1; end
        xfer_cnt = 0; fd_cnt = 0; last_cls = -1; last_idx = -1;
        send({48'h0BAD_F00D_CAFE, 16'(f.cal)}, 1'b0, 1'b0, 0, 32'd0, st);
        chk("cal_num", 192'(cal_num), 192'(f.cal));
        chk("mat_valid_hdr", 192'(mat_valid), 192'(1'b0));
        chk("err_hdr", 192'(err), 192'(1'b0));
        tot_stall = 0;
        for (int i = 0; i < 19; i++) begin
            send({32'hDEAD_BEEF, wt[i]}, 1'(i == f.bad_w), 1'b1, i, wt[i], st);
            tot_stall += st;
        end
        if (f.bad_w >= 0) chk("err_set", 192'(err), 192'(1'b1));
        // Lane 3 is the most significant 16 bits of each row beat.
        rows[0] = {16'hB000, 16'h0000, 16'h0000, 16'd41};
        rows[1] = {16'hC000, 16'h0000, 16'd41,   16'h0000};
        rows[2] = {16'hBB33, 16'd41,   16'h0000, 16'h0000};
        for (int r = 0; r < 3; r++) begin
            send(rows[r], 1'b0, 1'b0, 0, 32'd0, st);
            tot_stall += st;
            if (r < 2) chk("mat_valid_lo", 192'(mat_valid), 192'(1'b0));
        end
        chk("mat_valid_hi", 192'(mat_valid), 192'(1'b1));
        chk("mat", 192'(mat), {rows[2], rows[1], rows[0]});
        chk("mat_el3", 192'(mat[48 +: 16]), 192'(16'hB000));
        nvec = 12 + f.cal;
        for (int n = 0; n < nvec && (f.stop_after < 0 || n < f.stop_after); n++) begin
            if (n < 4)       begin cls = 0; idx = n;      end
            else if (n < 10) begin cls = 1; idx = n - 4;  end
            else if (n < 12) begin cls = 2; idx = n - 10; end
            else             begin cls = 3; idx = n - 12; end
            d = {16'hA000 | 16'(n), 16'(f.cal), 16'h5A5A, 16'(n * 7)};
            exp_q.push_back({d, 2'(cls), 16'(idx), 1'(n == nvec - 1)});
            send(d, 1'(n == nvec - 1), 1'b0, 0, 32'd0, st);
            tot_stall += st;
        end
        if (f.stop_after >= 0) return;
        if (f.bp == 0) chk("no_stall", 192'(tot_stall), 192'(0));
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(posedge aclk);
        #1;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout: got %0d pending vectors, expected 0", exp_q.size());
            exp_q.delete();
        end
        chk("nvec", 192'(xfer_cnt), 192'(f.exp_nvec));
        chk("frame_done_cnt", 192'(fd_cnt), 192'(1));
        chk("last_cls", 192'(last_cls), 192'(f.exp_last_cls));
        chk("last_idx", 192'(last_idx), 192'(f.exp_last_idx));
        chk("err_end", 192'(err), 192'(f.exp_err));
        chk("s_tready_hdr", 192'(s_tready), 192'(1'b1));
    endtask

    initial begin
        n_vec = 0; n_miss = 0; bp_mode = 0;
        xfer_cnt = 0; fd_cnt = 0; last_cls = -1; last_idx = -1;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        wt[0]  = 32'h000162C0;   // 90816
        wt[1]  = 32'hFFFD9B18;   // -156904
        for (int i = 2; i < 18; i++) wt[i] = 32'(i * 4099 - 30000);
        wt[18] = 32'd101872;
        //             cal bad bp gap stop nvec err lcls lidx
        tbl[0] = mk(3, -1, 0, 0,  -1, 15, 1'b0, 3, 2);
        tbl[1] = mk(3, -1, 0, 0,  -1, 15, 1'b0, 3, 2);
        tbl[2] = mk(3, -1, 0, 50, -1, 15, 1'b0, 3, 2);
        tbl[3] = mk(5, -1, 1, 0,  -1, 17, 1'b0, 3, 4);
        tbl[4] = mk(8, -1, 2, 0,  -1, 20, 1'b0, 3, 7);
        tbl[5] = mk(0, -1, 0, 0,  -1, 12, 1'b0, 2, 1);
        tbl[6] = mk(0, -1, 1, 0,  -1, 12, 1'b0, 2, 1);
        tbl[7] = mk(2,  5, 0, 0,  -1, 14, 1'b1, 3, 1);
        tbl[8] = mk(1, -1, 2, 0,  -1, 13, 1'b0, 3, 0);

        areset = 1'b0;
        #2 areset = 1'b1;
        @(negedge aclk);
        check_reset_vals();
        @(posedge aclk); #1;
        areset = 1'b0;

        for (int i = 0; i < 9; i++) run_frame(tbl[i]);

        // Mid-frame reset after seven vectors, with a vector likely still held downstream.
        run_frame(mk(3, -1, 1, 0, 7, 15, 1'b0, 3, 2));
        areset = 1'b1;
        @(negedge aclk);
        check_reset_vals();
        exp_q.delete();
        @(posedge aclk); #1;
        areset = 1'b0;
        run_frame(mk(3, -1, 0, 0, -1, 15, 1'b0, 3, 2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
